muldiv_unit: RTL and testbench

//  Multi-cycle unsigned multiply/divide unit for the S1C88 core, executing MLT (L*A->HL) and
//  DIV (HL/A -> L=quotient, H=remainder) beside the combinational alu. Operand width and

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit: shift-add MUL (L*A->HL) and restoring DIV
// (HL/A -> {rem, quo}), retiring STEP bits per cycle behind a start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [2*WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [2*WIDTH-1:0]   R,
  output logic [3:0]           flags
);

  localparam int W2 = 2 * WIDTH;
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            op_reg;
  logic [W2-1:0]   work_reg;   // MUL: accumulator; DIV: {partial remainder, quotient}
  logic [W2-1:0]   aux_reg;    // MUL: shifted multiplicand; DIV: divisor in low half
  logic [WIDTH-1:0] mplr_reg;
  logic [W2-1:0]   r_reg;
  logic [3:0]      flags_reg;
  logic            div_zero_reg;

  logic accept, err_zero, err_ovf, last_step;

  // Next-state and accept decode
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    err_zero   = 1'b0;
    err_ovf    = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (state_reg == ST_DONE) state_next = ST_IDLE;
        if (start) begin
          accept = 1'b1;
          if (op && (B == '0)) begin
            err_zero   = 1'b1;
            state_next = ST_DONE;
          end else if (op && (A[W2-1:WIDTH] >= B)) begin
            err_ovf    = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt_reg == CW'(1)) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Per-cycle datapath: a chain of STEP single-bit stages for each operation
  logic [W2-1:0]    mul_acc_c [0:STEP];
  logic [W2-1:0]    mul_mc_c  [0:STEP];
  logic [WIDTH-1:0] mul_mp_c  [0:STEP];
  logic [WIDTH-1:0] div_rem_c [0:STEP];
  logic [WIDTH-1:0] div_quo_c [0:STEP];
  logic [WIDTH-1:0] divisor;

  assign mul_acc_c[0] = work_reg;
  assign mul_mc_c[0]  = aux_reg;
  assign mul_mp_c[0]  = mplr_reg;
  assign div_rem_c[0] = work_reg[W2-1:WIDTH];
  assign div_quo_c[0] = work_reg[WIDTH-1:0];
  assign divisor      = aux_reg[WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_step
      logic [WIDTH:0] ext;
      logic           ge;
      assign mul_acc_c[gi+1] = mul_acc_c[gi] + (mul_mp_c[gi][0] ? mul_mc_c[gi] : '0);
      assign mul_mc_c[gi+1]  = mul_mc_c[gi] << 1;
      assign mul_mp_c[gi+1]  = mul_mp_c[gi] >> 1;
      // W+1 bit trial remainder; the difference always fits W bits since rem < divisor
      assign ext             = {div_rem_c[gi], div_quo_c[gi][WIDTH-1]};
      assign ge              = (ext >= {1'b0, divisor});
      assign div_rem_c[gi+1] = ge ? (ext[WIDTH-1:0] - divisor) : ext[WIDTH-1:0];
      assign div_quo_c[gi+1] = {div_quo_c[gi][WIDTH-2:0], ge};
    end
  endgenerate

  logic [W2-1:0] step_result;
  logic [3:0]    res_flags;

  assign step_result = op_reg ? {div_rem_c[STEP], div_quo_c[STEP]} : mul_acc_c[STEP];

  always_comb begin
    if (op_reg) res_flags = {step_result[WIDTH-1], 2'b00, (step_result[WIDTH-1:0] == '0)};
    else        res_flags = {step_result[W2-1], 2'b00, (step_result == '0)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      op_reg       <= 1'b0;
      work_reg     <= '0;
      aux_reg      <= '0;
      mplr_reg     <= '0;
      r_reg        <= '0;
      flags_reg    <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      div_zero_reg <= 1'b0;
      if (accept) begin
        op_reg   <= op;
        cnt_reg  <= CW'(N);
        work_reg <= op ? A : '0;
        aux_reg  <= op ? {{WIDTH{1'b0}}, B} : {{WIDTH{1'b0}}, A[WIDTH-1:0]};
        mplr_reg <= B;
        if (err_zero || err_ovf) begin
          r_reg        <= A;
          flags_reg    <= err_ovf ? 4'b0100 : 4'b0000;
          div_zero_reg <= err_zero;
        end
      end else if (state_reg == ST_RUN) begin
        cnt_reg  <= cnt_reg - CW'(1);
        work_reg <= step_result;
        aux_reg  <= op_reg ? aux_reg : mul_mc_c[STEP];
        mplr_reg <= mul_mp_c[STEP];
        if (last_step) begin
          r_reg     <= step_result;
          flags_reg <= res_flags;
        end
      end
    end
  end

  assign busy     = (state_reg == ST_RUN);
  assign done     = (state_reg == ST_DONE);
  assign div_zero = div_zero_reg;
  assign R        = r_reg;
  assign flags    = flags_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, hand-written handshake/reset sequences and
// random operations checked against an arithmetic reference model (W=8,S=1 and W=16,S=2).
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, op;
  logic [15:0] a;
  logic [7:0]  b;
  logic        busy, done, div_zero;
  logic [15:0] r;
  logic [3:0]  flags;

  logic        start16, op16;
  logic [31:0] a16;
  logic [15:0] b16;
  logic        busy16, done16, div_zero16;
  logic [31:0] r16;
  logic [3:0]  flags16;

  muldiv_unit #(.WIDTH(8), .STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .div_zero(div_zero), .R(r), .flags(flags)
  );

  muldiv_unit #(.WIDTH(16), .STEP(2)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .div_zero(div_zero16), .R(r16), .flags(flags16)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        o;
    logic [15:0] av;
    logic [7:0]  bv;
    logic [15:0] er;
    logic [3:0]  ef;
    logic        ez;
    int          el;
  } vec_t;

  vec_t vecs[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operands
  task automatic ref8(input logic o, input logic [15:0] av, input logic [7:0] bv,
                      output logic [15:0] er, output logic [3:0] ef, output logic ez,
                      output int el);
    int unsigned p, q, rm;
    ez = 1'b0;
    if (!o) begin
      p  = av[7:0] * bv;
      er = p[15:0];
      ef = {er[15], 2'b00, (er == 16'h0)};
      el = 9;
    end else if (bv == 8'h0) begin
      er = av; ef = 4'b0000; ez = 1'b1; el = 1;
    end else if (av[15:8] >= bv) begin
      er = av; ef = 4'b0100; el = 1;
    end else begin
      q  = av / bv;
      rm = av % bv;
      er = {rm[7:0], q[7:0]};
      ef = {q[7], 2'b00, (q[7:0] == 8'h0)};
      el = 9;
    end
  endtask

  task automatic ref16(input logic o, input logic [31:0] av, input logic [15:0] bv,
                       output logic [31:0] er, output logic [3:0] ef, output logic ez,
                       output int el);
    longint unsigned p, q, rm;
    ez = 1'b0;
    if (!o) begin
      p  = 64'(av[15:0]) * 64'(bv);
      er = p[31:0];
      ef = {er[31], 2'b00, (er == 32'h0)};
      el = 9;
    end else if (bv == 16'h0) begin
      er = av; ef = 4'b0000; ez = 1'b1; el = 1;
    end else if (av[31:16] >= bv) begin
      er = av; ef = 4'b0100; el = 1;
    end else begin
      q  = 64'(av) / 64'(bv);
      rm = 64'(av) % 64'(bv);
      er = {rm[15:0], q[15:0]};
      ef = {q[15], 2'b00, (q[15:0] == 16'h0)};
      el = 9;
    end
  endtask

  // Issue one op; returns cycles from accept edge to the first cycle with done high.
  // Operands are scrambled during RUN, which must not matter.
  task automatic do_op8(input logic o, input logic [15:0] av, input logic [7:0] bv, output int lat);
    op = o; a = av; b = bv; start = 1'b1;
    tick;
    start = 1'b0;
    op = 1'($urandom); a = 16'($urandom); b = 8'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      chk("busy_in_run", 64'(busy), 64'(1));
      tick;
      lat++;
    end
  endtask

  task automatic do_op16(input logic o, input logic [31:0] av, input logic [15:0] bv, output int lat);
    op16 = o; a16 = av; b16 = bv; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    op16 = 1'($urandom); a16 = $urandom; b16 = 16'($urandom);
    lat = 1;
    while (!done16 && lat < 40) begin
      chk("busy16_in_run", 64'(busy16), 64'(1));
      tick;
      lat++;
    end
  endtask

  task automatic check8(input string tag, input logic o, input logic [15:0] av, input logic [7:0] bv,
                        input logic [15:0] er, input logic [3:0] ef, input logic ez,
                        input int el, input int lat);
    chk({tag, "_latency"}, 64'(lat), 64'(el));
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_R"}, 64'(r), 64'(er));
    chk({tag, "_flags"}, 64'(flags), 64'(ef));
    chk({tag, "_div_zero"}, 64'(div_zero), 64'(ez));
    $display("%s op=%0d A=%h B=%h -> R=%h flags=%b dz=%0d lat=%0d", tag, o, av, bv, r, flags, div_zero, lat);
  endtask

  task automatic hold8(input string tag, input logic [15:0] er, input logic [3:0] ef);
    tick;
    chk({tag, "_done_drop"}, 64'(done), 64'(0));
    chk({tag, "_dz_drop"}, 64'(div_zero), 64'(0));
    chk({tag, "_R_hold"}, 64'(r), 64'(er));
    chk({tag, "_flags_hold"}, 64'(flags), 64'(ef));
  endtask

  initial begin
    logic [15:0] er, av;
    logic [3:0]  ef;
    logic        ez, o;
    logic [7:0]  bv;
    logic [31:0] er16, av16;
    logic [15:0] bv16;
    int          lat, el, seen;

    vecs[0]  = '{1'b0, 16'h00FF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 9};
    vecs[1]  = '{1'b1, 16'h0123, 8'h10, 16'h0312, 4'b0000, 1'b0, 9};
    vecs[2]  = '{1'b1, 16'h1234, 8'h12, 16'h1234, 4'b0100, 1'b0, 1};
    vecs[3]  = '{1'b1, 16'h0042, 8'h00, 16'h0042, 4'b0000, 1'b1, 1};
    vecs[4]  = '{1'b0, 16'hAB00, 8'h37, 16'h0000, 4'b0001, 1'b0, 9};
    vecs[5]  = '{1'b0, 16'h0002, 8'h03, 16'h0006, 4'b0000, 1'b0, 9};
    vecs[6]  = '{1'b1, 16'h00FF, 8'h01, 16'h00FF, 4'b1000, 1'b0, 9};
    vecs[7]  = '{1'b1, 16'h7FFF, 8'h80, 16'h7FFF, 4'b1000, 1'b0, 9};
    vecs[8]  = '{1'b1, 16'h0005, 8'h07, 16'h0500, 4'b0001, 1'b0, 9};
    vecs[9]  = '{1'b0, 16'h0080, 8'h02, 16'h0100, 4'b0000, 1'b0, 9};
    vecs[10] = '{1'b1, 16'h0800, 8'h08, 16'h0800, 4'b0100, 1'b0, 1};
    vecs[11] = '{1'b0, 16'h12FF, 8'h00, 16'h0000, 4'b0001, 1'b0, 9};

    reset_n = 1'b0;
    start = 1'b0; op = 1'b0; a = '0; b = '0;
    start16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0;
    tick; tick; tick;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div_zero", 64'(div_zero), 64'(0));
    chk("rst_R", 64'(r), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    chk("rst16_R", 64'(r16), 64'(0));
    reset_n = 1'b1;
    tick;

    for (int i = 0; i < 12; i++) begin
      do_op8(vecs[i].o, vecs[i].av, vecs[i].bv, lat);
      check8($sformatf("vec%0d", i), vecs[i].o, vecs[i].av, vecs[i].bv,
             vecs[i].er, vecs[i].ef, vecs[i].ez, vecs[i].el, lat);
      hold8($sformatf("vec%0d", i), vecs[i].er, vecs[i].ef);
    end

    // start pulsed mid-run with a would-be DIV-by-zero must be ignored
    op = 1'b0; a = 16'hAB00; b = 8'h37; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 3) begin start = 1'b1; op = 1'b1; a = 16'h0042; b = 8'h00; end
      else start = 1'b0;
      tick;
      lat++;
    end
    start = 1'b0;
    check8("ignore_start", 1'b0, 16'hAB00, 8'h37, 16'h0000, 4'b0001, 1'b0, 9, lat);

    // back-to-back: start in the DONE cycle
    op = 1'b0; a = 16'h00FF; b = 8'hFF; start = 1'b1;
    tick;
    start = 1'b0;
    chk("b2b_done_drop", 64'(done), 64'(0));
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_R_hold", 64'(r), 64'(0));
    lat = 1;
    while (!done && lat < 40) begin tick; lat++; end
    check8("b2b_mul", 1'b0, 16'h00FF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 9, lat);

    // back-to-back into an error op: done stays high
    op = 1'b1; a = 16'h0042; b = 8'h00; start = 1'b1;
    tick;
    start = 1'b0;
    check8("b2b_divzero", 1'b1, 16'h0042, 8'h00, 16'h0042, 4'b0000, 1'b1, 1, 1);
    hold8("b2b_divzero", 16'h0042, 4'b0000);

    // reset in the middle of a DIV
    op = 1'b1; a = 16'h0123; b = 8'h10; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_R", 64'(r), 64'(0));
    chk("midrst_flags", 64'(flags), 64'(0));
    tick; tick;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done || busy) seen++;
    end
    chk("no_done_after_reset", 64'(seen), 64'(0));
    $display("reset mid-DIV: idle cycles observed with done/busy=%0d", seen);

    // randomized ops against the model, mixing idle gaps and back-to-back issue
    for (int i = 0; i < 200; i++) begin
      o  = 1'($urandom);
      bv = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom);
      av = 16'($urandom);
      if (o && bv != 8'h00 && $urandom_range(3, 0) != 0)
        av[15:8] = 8'($urandom_range(32'(bv) - 1, 0));
      ref8(o, av, bv, er, ef, ez, el);
      do_op8(o, av, bv, lat);
      check8($sformatf("rnd%0d", i), o, av, bv, er, ef, ez, el, lat);
      if ($urandom_range(1, 0) == 1) hold8($sformatf("rnd%0d", i), er, ef);
    end

    // W=16, STEP=2 instance
    do_op16(1'b0, 32'h0000FFFF, 16'hFFFF, lat);
    chk("w16_mul_latency", 64'(lat), 64'(9));
    chk("w16_mul_R", 64'(r16), 64'h00000000FFFE0001);
    chk("w16_mul_flags", 64'(flags16), 64'(4'b1000));
    $display("w16 MUL A=0000ffff B=ffff -> R=%h flags=%b lat=%0d", r16, flags16, lat);
    tick;
    do_op16(1'b1, 32'h00FF0000, 16'h0100, lat);
    chk("w16_div_latency", 64'(lat), 64'(9));
    chk("w16_div_R", 64'(r16), 64'h000000000000FF00);
    chk("w16_div_flags", 64'(flags16), 64'(4'b1000));
    $display("w16 DIV A=00ff0000 B=0100 -> R=%h flags=%b lat=%0d", r16, flags16, lat);
    tick;
    for (int i = 0; i < 40; i++) begin
      o    = 1'($urandom);
      bv16 = ($urandom_range(7, 0) == 0) ? 16'h0 : 16'($urandom);
      av16 = $urandom;
      if (o && bv16 != 16'h0 && $urandom_range(3, 0) != 0)
        av16[31:16] = 16'($urandom_range(32'(bv16) - 1, 0));
      ref16(o, av16, bv16, er16, ef, ez, el);
      do_op16(o, av16, bv16, lat);
      chk("w16_rnd_latency", 64'(lat), 64'(el));
      chk("w16_rnd_R", 64'(r16), 64'(er16));
      chk("w16_rnd_flags", 64'(flags16), 64'(ef));
      chk("w16_rnd_div_zero", 64'(div_zero16), 64'(ez));
      $display("w16 rnd%0d op=%0d A=%h B=%h -> R=%h flags=%b lat=%0d", i, o, av16, bv16, r16, flags16, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
